// File: rtl/pkt_rx_check.sv
// pkt_rx_check: framing checker for a head/data/tail packet stream.
// For each packet that closes, good or aborted, it reports the length
// (pkt_len) and an XOR checksum (pkt_csum). It flags framing errors:
//   1 = orphan beat, 2 = nested head, 3 = overlength.
// It also keeps saturating counters of good packets and error events.
// Optional feature: define PKT_RX_CHECKSUM_EN to build the checksum
// accumulator. Without it pkt_csum is tied to zero.
module pkt_rx_check #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              head,
    input  logic              tail,
    input  logic [DATA_W-1:0] data,
    output logic              in_pkt,
    output logic              pkt_done,
    output logic              pkt_ok,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [DATA_W-1:0] pkt_csum,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BODY  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d, len_inc_s;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                in_pkt_q, done_q, done_d, ok_q, ok_d, err_q, err_d;
    logic [LEN_W-1:0]    plen_q, plen_d;
    logic [1:0]          code_q, code_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

    assign len_inc_s = len_q + LEN_W'(1);

    // Next-state, packet bookkeeping and report decode for the sampled beat.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        plen_d  = plen_q;
        csum_d  = csum_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (valid && head) begin
                    state_d = S_BODY;
                    len_d   = LEN_W'(1);
                    acc_d   = data;
                end else if (valid) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BODY: begin
                if (valid && head) begin
                    // Abort the open packet and restart from this beat.
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    code_d = 2'd2;
                    plen_d = len_q;
                    csum_d = acc_q;
                    len_d  = LEN_W'(1);
                    acc_d  = data;
                end else if (valid && tail) begin
                    // len_q never exceeds MAX_LEN-1 here, so the tail always fits.
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    plen_d  = len_inc_s;
                    csum_d  = acc_q ^ data;
                    state_d = S_IDLE;
                end else if (valid && (len_inc_s == LEN_W'(MAX_LEN))) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    plen_d  = LEN_W'(MAX_LEN);
                    csum_d  = acc_q ^ data;
                    state_d = S_DRAIN;
                end else if (valid) begin
                    len_d = len_inc_s;
                    acc_d = acc_q ^ data;
                end else begin
                    state_d = S_BODY;
                end
            end
            S_DRAIN: begin
                if (valid && head) begin
                    state_d = S_BODY;
                    len_d   = LEN_W'(1);
                    acc_d   = data;
                end else if (valid && tail) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating statistics, updated together with the report pulse.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (done_d && ok_d && (pkt_cnt_q != {CNT_W{1'b1}})) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, length and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            len_q     <= {LEN_W{1'b0}};
            in_pkt_q  <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            plen_q    <= {LEN_W{1'b0}};
            code_q    <= 2'd0;
            pkt_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_pkt_q  <= (state_d == S_BODY);
            done_q    <= done_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            plen_q    <= plen_d;
            code_q    <= code_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef PKT_RX_CHECKSUM_EN
    // Checksum accumulator and reported checksum register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= {DATA_W{1'b0}};
            csum_q <= {DATA_W{1'b0}};
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end
`else
    // No accumulator: the checksum path collapses to constant zero.
    logic unused_csum_s;
    assign acc_q         = {DATA_W{1'b0}};
    assign csum_q        = {DATA_W{1'b0}};
    assign unused_csum_s = ^{acc_d, csum_d};
`endif

    assign in_pkt    = in_pkt_q;
    assign pkt_done  = done_q;
    assign pkt_ok    = ok_q;
    assign pkt_len   = plen_q;
    assign pkt_csum  = csum_q;
    assign err_valid = err_q;
    assign err_code  = code_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pkt_rx_check.sv
// Self-checking bench for pkt_rx_check. A vector table plus hand-written
// sequences drive beats; each beat's expected next-cycle outputs are queued
// and compared one cycle later.
module tb_pkt_rx_check;

`ifdef PKT_RX_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid, head, tail;
    logic [7:0] data;
    logic       in_pkt, pkt_done, pkt_ok, err_valid;
    logic [4:0] pkt_len;
    logic [7:0] pkt_csum;
    logic [1:0] err_code;
    logic [7:0] pkt_cnt, err_cnt;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic       v, h, t;
        logic [7:0] d;
        logic       ip, dn, ok;
        logic [4:0] len;
        logic [7:0] cs;
        logic       er;
        logic [1:0] cd;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[27];

    pkt_rx_check dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .head(head), .tail(tail),
        .data(data), .in_pkt(in_pkt), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
        .pkt_len(pkt_len), .pkt_csum(pkt_csum), .err_valid(err_valid),
        .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic h, input logic t, input logic [7:0] d,
                                input logic ip, input logic dn, input logic ok, input logic [4:0] len,
                                input logic [7:0] cs, input logic er, input logic [1:0] cd);
        vec_t r;
        r.v = v; r.h = h; r.t = t; r.d = d; r.ip = ip; r.dn = dn; r.ok = ok;
        r.len = len; r.cs = cs; r.er = er; r.cd = cd;
        return r;
    endfunction

    task automatic step(input vec_t e);
        @(negedge clk);
        valid = e.v; head = e.h; tail = e.t; data = e.d;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic ip);
        step(mk(1'b0, 1'b0, 1'b0, 8'h00, ip, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd0));
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: the beat sampled at this edge produced the outputs seen now.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            vec_t e;
            logic [7:0] ecs;
            logic bad;
            e   = sb_q.pop_front();
            ecs = CS_EN ? e.cs : 8'h00;
            bad = (in_pkt !== e.ip) || (pkt_done !== e.dn) || (err_valid !== e.er);
            if (e.dn) bad = bad || (pkt_ok !== e.ok) || (pkt_len !== e.len) || (pkt_csum !== ecs);
            if (e.er) bad = bad || (err_code !== e.cd);
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL vec@%0t: got ip=%b done=%b ok=%b len=%0d cs=%h err=%b code=%0d expected ip=%b done=%b ok=%b len=%0d cs=%h err=%b code=%0d",
                         $time, in_pkt, pkt_done, pkt_ok, pkt_len, pkt_csum, err_valid, err_code,
                         e.ip, e.dn, e.ok, e.len, ecs, e.er, e.cd);
            end
        end
    end

    initial begin
        //            v  h  t  data   ip dn ok len  csum   er cd
        tbl[0]  = mk(1, 1, 0, 8'h11, 1, 0, 0, 0,  8'h00, 0, 0); // good packet
        tbl[1]  = mk(1, 0, 0, 8'h22, 1, 0, 0, 0,  8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 1, 8'h44, 0, 1, 1, 3,  8'h77, 0, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0);
        tbl[4]  = mk(1, 1, 0, 8'hAA, 1, 0, 0, 0,  8'h00, 0, 0); // gaps
        tbl[5]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 0,  8'h00, 0, 0);
        tbl[6]  = mk(0, 0, 1, 8'hFF, 1, 0, 0, 0,  8'h00, 0, 0);
        tbl[7]  = mk(1, 0, 1, 8'h0F, 0, 1, 1, 2,  8'hA5, 0, 0);
        tbl[8]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0);
        tbl[9]  = mk(1, 0, 1, 8'h33, 0, 0, 0, 0,  8'h00, 1, 1); // orphans
        tbl[10] = mk(1, 0, 0, 8'h55, 0, 0, 0, 0,  8'h00, 1, 1);
        tbl[11] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0);
        tbl[12] = mk(1, 1, 0, 8'h01, 1, 0, 0, 0,  8'h00, 0, 0); // nested head
        tbl[13] = mk(1, 0, 0, 8'h02, 1, 0, 0, 0,  8'h00, 0, 0);
        tbl[14] = mk(1, 1, 0, 8'h04, 1, 1, 0, 2,  8'h03, 1, 2);
        tbl[15] = mk(1, 0, 1, 8'h08, 0, 1, 1, 2,  8'h0C, 0, 0);
        tbl[16] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0);
        tbl[17] = mk(1, 1, 0, 8'h10, 1, 0, 0, 0,  8'h00, 0, 0); // back-to-back
        tbl[18] = mk(1, 0, 1, 8'h20, 0, 1, 1, 2,  8'h30, 0, 0);
        tbl[19] = mk(1, 1, 0, 8'h40, 1, 0, 0, 0,  8'h00, 0, 0);
        tbl[20] = mk(1, 0, 1, 8'h80, 0, 1, 1, 2,  8'hC0, 0, 0);
        tbl[21] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0);
        tbl[22] = mk(1, 1, 0, 8'h01, 1, 0, 0, 0,  8'h00, 0, 0); // head+tail in body
        tbl[23] = mk(1, 1, 1, 8'h02, 1, 1, 0, 1,  8'h01, 1, 2);
        tbl[24] = mk(1, 0, 1, 8'h04, 0, 1, 1, 2,  8'h06, 0, 0);
        tbl[25] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0);
        tbl[26] = mk(0, 1, 1, 8'hFF, 0, 0, 0, 0,  8'h00, 0, 0); // invalid ignored

        reset_n = 1'b0; valid = 1'b0; head = 1'b0; tail = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_pkt", in_pkt, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_err", err_valid, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) step(tbl[i]);
        idle(1'b0);
        @(negedge clk);
        chk("tbl_pkt_cnt", pkt_cnt, 6);
        chk("tbl_err_cnt", err_cnt, 4);

        // Overlength: head + 15 data beats; beat 16 aborts, then drain.
        step(mk(1, 1, 0, 8'h01, 1, 0, 0, 0, 8'h00, 0, 0));
        for (int k = 2; k <= 15; k++) step(mk(1, 0, 0, 8'(k), 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 0, 8'h10, 0, 1, 0, 16, 8'h10, 1, 3));
        for (int k = 0; k < 3; k++) step(mk(1, 0, 0, 8'h5A, 0, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 1, 8'h66, 0, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 1, 0, 8'h0A, 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 1, 8'h05, 0, 1, 1, 2, 8'h0F, 0, 0));

        // Tail on beat MAX_LEN is still a good packet.
        step(mk(1, 1, 0, 8'h01, 1, 0, 0, 0, 8'h00, 0, 0));
        for (int k = 2; k <= 15; k++) step(mk(1, 0, 0, 8'(k), 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 1, 8'h10, 0, 1, 1, 16, 8'h10, 0, 0));

        // Overlength, then a head in drain opens a packet with no extra error.
        step(mk(1, 1, 0, 8'h01, 1, 0, 0, 0, 8'h00, 0, 0));
        for (int k = 2; k <= 15; k++) step(mk(1, 0, 0, 8'(k), 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 0, 8'h10, 0, 1, 0, 16, 8'h10, 1, 3));
        step(mk(1, 0, 0, 8'h77, 0, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 1, 0, 8'h21, 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 1, 8'h12, 0, 1, 1, 2, 8'h33, 0, 0));
        idle(1'b0);
        @(negedge clk);
        chk("ovl_pkt_cnt", pkt_cnt, 9);
        chk("ovl_err_cnt", err_cnt, 6);

        // Reset mid-packet.
        step(mk(1, 1, 0, 8'h31, 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 0, 8'h32, 1, 0, 0, 0, 8'h00, 0, 0));
        @(posedge clk);
        #2;
        reset_n = 1'b0; valid = 1'b0; head = 1'b0; tail = 1'b0;
        #1;
        chk("mid_rst_in_pkt", in_pkt, 0);
        chk("mid_rst_done", pkt_done, 0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(mk(1, 1, 1, 8'h03, 1, 0, 0, 0, 8'h00, 0, 0));
        step(mk(1, 0, 1, 8'h05, 0, 1, 1, 2, 8'h06, 0, 0));
        idle(1'b0);

        // Error counter saturation.
        for (int k = 0; k < 260; k++) step(mk(1, 0, 0, 8'(k), 0, 0, 0, 0, 8'h00, 1, 1));
        idle(1'b0);
        @(negedge clk);
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_pkt_cnt", pkt_cnt, 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
